dl11_serial_if: RTL

DL11_SERIAL_IF -- requirements
Module: dl11_serial_if

---
 rtl/dl11_pkg.sv | 21 ++
 rtl/dl11_rx_fifo.sv | 66 ++++++
 rtl/dl11_serial_if.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 serial interface: register offsets, CSR bit
// positions and transmit state encoding.
package dl11_pkg;

    localparam logic [1:0] ADDR_RCSR = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_XCSR = 2'd2;
    localparam logic [1:0] ADDR_XBUF = 2'd3;

    localparam int CSR_DONE_BIT  = 7;
    localparam int CSR_READY_BIT = 7;
    localparam int CSR_IE_BIT    = 6;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_ARM   = 2'd1,
        T_SEND  = 2'd2,
        T_DRAIN = 2'd3
    } tx_state_t;

endpackage

// File: rtl/dl11_rx_fifo.sv
// Receive byte FIFO for the DL11 interface; only instantiated when
// DL11_RX_FIFO_EN is defined. An empty FIFO keeps presenting the last popped byte.
module dl11_rx_fifo import dl11_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    last_r;
    logic          push_s;
    logic          pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            ptr_inc = {AW{1'b0}};
        end else begin
            ptr_inc = p + AW'(1'b1);
        end
    endfunction

    assign empty  = (count_r == {(AW + 1){1'b0}});
    assign full   = (count_r == (AW + 1)'(DEPTH));
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign dout   = empty ? last_r : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            last_r   <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                last_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (AW + 1)'(1'b1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - (AW + 1)'(1'b1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/dl11_serial_if.sv
// DL11-style serial line register interface (RCSR/RBUF/XCSR/XBUF).
// Define DL11_RX_FIFO_EN to buffer received bytes in an RX_FIFO_DEPTH-entry FIFO.
module dl11_serial_if import dl11_pkg::*; #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rx_irq,
    output logic        tx_irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic        rx_clear,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready
);

    tx_state_t   state_r;
    tx_state_t   state_next_s;
    logic [15:0] rdata_r;
    logic [15:0] rd_mux_s;
    logic [7:0]  tx_data_r;
    logic [7:0]  rbuf_s;
    logic        tx_send_r;
    logic        rx_clear_r;
    logic        rx_irq_r;
    logic        tx_irq_r;
    logic        rie_r;
    logic        xie_r;
    logic        rd_s;
    logic        wr_s;
    logic        rbuf_rd_s;
    logic        xbuf_wr_s;
    logic        capture_s;
    logic        done_s;
    logic        ready_s;
    logic        unused_wdata_s;

    assign rd_s      = cs & ~we;
    assign wr_s      = cs & we;
    assign rbuf_rd_s = rd_s & (addr == ADDR_RBUF);
    assign xbuf_wr_s = wr_s & (addr == ADDR_XBUF);
    assign ready_s   = (state_r == T_IDLE);

    // The high byte of write data has no register behind it.
    assign unused_wdata_s = ^wdata[15:8];

`ifdef DL11_RX_FIFO_EN
    logic       fifo_empty_s;
    logic       fifo_full_s;
    logic [7:0] fifo_head_s;

    assign capture_s = rx_data_ready & ~rx_clear_r & ~fifo_full_s;
    assign done_s    = ~fifo_empty_s;
    assign rbuf_s    = fifo_head_s;

    dl11_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture_s),
        .pop   (rbuf_rd_s & ~fifo_empty_s),
        .din   (rx_data),
        .dout  (fifo_head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );
`else
    logic       done_r;
    logic [7:0] rbuf_r;

    // A read in the same cycle defers capture so the CPU never loses the old byte;
    // a zero-depth configuration disables reception entirely.
    assign capture_s = rx_data_ready & ~rx_clear_r & ~done_r & ~rbuf_rd_s
                       & (RX_FIFO_DEPTH != 0);
    assign done_s    = done_r;
    assign rbuf_s    = rbuf_r;

    // Single holding register: set on capture, released by an RBUF read.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
            rbuf_r <= 8'h00;
        end else if (capture_s) begin
            done_r <= 1'b1;
            rbuf_r <= rx_data;
        end else if (rbuf_rd_s) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_r;
        end
    end
`endif

    // Interrupt-enable bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rie_r <= 1'b0;
            xie_r <= 1'b0;
        end else begin
            if (wr_s && (addr == ADDR_RCSR)) begin
                rie_r <= wdata[CSR_IE_BIT];
            end
            if (wr_s && (addr == ADDR_XCSR)) begin
                xie_r <= wdata[CSR_IE_BIT];
            end
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (addr)
            ADDR_RCSR: begin
                rd_mux_s[CSR_DONE_BIT] = done_s;
                rd_mux_s[CSR_IE_BIT]   = rie_r;
            end
            ADDR_RBUF: rd_mux_s = {8'h00, rbuf_s};
            ADDR_XCSR: begin
                rd_mux_s[CSR_READY_BIT] = ready_s;
                rd_mux_s[CSR_IE_BIT]    = xie_r;
            end
            ADDR_XBUF: rd_mux_s = 16'h0000;
            default:   rd_mux_s = 16'h0000;
        endcase
    end

    // Transmit next-state logic; READY is simply "in T_IDLE".
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            T_IDLE: begin
                if (xbuf_wr_s) state_next_s = T_ARM;
                else           state_next_s = T_IDLE;
            end
            T_ARM: begin
                if (tx_ready) state_next_s = T_SEND;
                else          state_next_s = T_ARM;
            end
            T_SEND: begin
                if (!tx_ready) state_next_s = T_DRAIN;
                else           state_next_s = T_SEND;
            end
            T_DRAIN: begin
                if (tx_ready) state_next_s = T_IDLE;
                else          state_next_s = T_DRAIN;
            end
            default: state_next_s = T_DRAIN;
        endcase
    end

    // Transmit state and its registered outputs; reset waits out any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= T_DRAIN;
            tx_send_r <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            tx_send_r <= (state_next_s == T_SEND);
            if (ready_s && xbuf_wr_s) begin
                tx_data_r <= wdata[7:0];
            end
        end
    end

    // Read data, receive acknowledge and interrupt request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r    <= 16'h0000;
            rx_clear_r <= 1'b0;
            rx_irq_r   <= 1'b0;
            tx_irq_r   <= 1'b0;
        end else begin
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
            rx_clear_r <= capture_s;
            rx_irq_r   <= rie_r & done_s;
            tx_irq_r   <= xie_r & ready_s;
        end
    end

    assign rdata    = rdata_r;
    assign rx_clear = rx_clear_r;
    assign rx_irq   = rx_irq_r;
    assign tx_irq   = tx_irq_r;
    assign tx_data  = tx_data_r;
    assign tx_send  = tx_send_r;

endmodule
